// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential/branch/jump/trap next-PC selection with stall hold and a pending-redirect buffer.
// Optional misaligned-target trap is compiled in with `define PC_MISALIGN_CHK_EN.
module pc_sequencer #(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic            fetch_valid_o,
  output logic            redirect_pending_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            redir_req;
  logic [XLEN-1:0] new_tgt;
  logic [XLEN-1:0] apply_tgt;
`ifdef PC_MISALIGN_CHK_EN
  logic            misalign_q, misalign_d;
`endif

  assign redir_req = jump_i | branch_i;
  // Jump beats branch; JAL/JALR targets always have bit 0 cleared.
  assign new_tgt   = jump_i ? {jump_target_i[XLEN-1:1], 1'b0} : branch_target_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    apply_tgt  = pend_tgt_q;
`ifdef PC_MISALIGN_CHK_EN
    misalign_d = 1'b0;
`endif
    if (trap_i) begin
      pc_d    = TRAP_VECTOR;
      state_d = BUBBLE;
      pend_d  = 1'b0;
    end else if (stall_i || (state_q != RUN)) begin
      // Redirects that cannot be applied now are parked; newest one wins.
      if (redir_req) begin
        pend_d     = 1'b1;
        pend_tgt_d = new_tgt;
      end
      if (!stall_i) begin
        state_d = RUN;
      end
    end else if (redir_req || pend_q) begin
      apply_tgt = redir_req ? new_tgt : pend_tgt_q;
      state_d   = BUBBLE;
      pend_d    = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      if (apply_tgt[1:0] != 2'b00) begin
        pc_d       = TRAP_VECTOR;
        misalign_d = 1'b1;
      end else begin
        pc_d = apply_tgt;
      end
`else
      pc_d = apply_tgt;
`endif
    end else begin
      pc_d = pc_q + XLEN'(INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o               = pc_q;
  assign pc_inc_o           = pc_q + XLEN'(INC);
  assign fetch_valid_o      = (state_q == RUN);
  assign redirect_pending_o = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirects, priority, stall buffering, wrap, misalign and mid-run reset.
module tb_pc_sequencer;
  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        trap_i;
  logic [31:0] pc_o;
  logic [31:0] pc_inc_o;
  logic        fetch_valid_o;
  logic        redirect_pending_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall_i),
    .branch_i           (branch_i),
    .branch_target_i    (branch_target_i),
    .jump_i             (jump_i),
    .jump_target_i      (jump_target_i),
    .trap_i             (trap_i),
    .pc_o               (pc_o),
    .pc_inc_o           (pc_inc_o),
    .fetch_valid_o      (fetch_valid_o),
    .redirect_pending_o (redirect_pending_o),
    .misalign_o         (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_i = 1'b0; jump_i = 1'b0; trap_i = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic fv, input logic pend);
    check({tag, "_pc"},   pc_o, pc);
    check({tag, "_fv"},   {31'd0, fetch_valid_o}, {31'd0, fv});
    check({tag, "_pend"}, {31'd0, redirect_pending_o}, {31'd0, pend});
  endtask

  initial begin
    rst_n = 1'b1; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; trap_i = 1'b0;
    branch_target_i = '0; jump_target_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check_state("async_reset", 32'h0, 1'b0, 1'b0);
    check("async_reset_mis", {31'd0, misalign_o}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    check_state("boot", 32'h0, 1'b0, 1'b0);
    tick(); check_state("run0", 32'h0, 1'b1, 1'b0);
    tick(); check_state("run4", 32'h4, 1'b1, 1'b0);
    tick(); check_state("run8", 32'h8, 1'b1, 1'b0);
    check("pc_inc8", pc_inc_o, 32'hC);
    tick(); tick(); check_state("run10", 32'h10, 1'b1, 1'b0);

    branch_i = 1'b1; branch_target_i = 32'h200;
    tick(); idle(); check_state("br_bubble", 32'h200, 1'b0, 1'b0);
    tick(); check_state("br_run", 32'h200, 1'b1, 1'b0);
    tick(); check_state("br_seq", 32'h204, 1'b1, 1'b0);

    trap_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h80; branch_i = 1'b1; branch_target_i = 32'h40;
    tick(); idle(); check_state("prio_trap", 32'h100, 1'b0, 1'b0);
    tick(); check_state("trap_run", 32'h100, 1'b1, 1'b0);
    jump_i = 1'b1; branch_i = 1'b1; jump_target_i = 32'h81; branch_target_i = 32'h40;
    tick(); idle(); check_state("jump_bit0", 32'h80, 1'b0, 1'b0);
    tick(); check_state("jump_run", 32'h80, 1'b1, 1'b0);

    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h300;
    tick(); idle(); check_state("stall1", 32'h80, 1'b1, 1'b1);
    tick(); check_state("stall2", 32'h80, 1'b1, 1'b1);
    tick(); check_state("stall3", 32'h80, 1'b1, 1'b1);
    stall_i = 1'b0;
    tick(); check_state("pend_apply", 32'h300, 1'b0, 1'b0);
    tick(); check_state("pend_run", 32'h300, 1'b1, 1'b0);

    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h400;
    tick(); idle(); check_state("stall_br", 32'h300, 1'b1, 1'b1);
    trap_i = 1'b1;
    tick(); idle(); check_state("stall_trap", 32'h100, 1'b0, 1'b0);
    stall_i = 1'b0;
    tick(); check_state("stall_trap_run", 32'h100, 1'b1, 1'b0);

    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h500;
    tick(); idle();
    jump_i = 1'b1; jump_target_i = 32'h601;
    tick(); idle(); check_state("overwrite_hold", 32'h100, 1'b1, 1'b1);
    stall_i = 1'b0;
    tick(); check_state("overwrite_apply", 32'h600, 1'b0, 1'b0);
    tick(); check_state("overwrite_run", 32'h600, 1'b1, 1'b0);

    branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick(); idle(); check_state("wrap_bubble", 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap_inc", pc_inc_o, 32'h0);
    tick(); check_state("wrap_run", 32'hFFFF_FFFC, 1'b1, 1'b0);
    tick(); check_state("wrap_zero", 32'h0, 1'b1, 1'b0);

    branch_i = 1'b1; branch_target_i = 32'h202;
    tick(); idle();
`ifdef PC_MISALIGN_CHK_EN
    check_state("misalign", 32'h100, 1'b0, 1'b0);
    check("misalign_pulse", {31'd0, misalign_o}, 32'd1);
`else
    check_state("misalign", 32'h202, 1'b0, 1'b0);
    check("misalign_pulse", {31'd0, misalign_o}, 32'd0);
`endif
    tick();
    check("misalign_clear", {31'd0, misalign_o}, 32'd0);
    check("misalign_run_fv", {31'd0, fetch_valid_o}, 32'd1);

    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h700;
    tick(); idle();
    check("midrst_pend_set", {31'd0, redirect_pending_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_state("midrst", 32'h0, 1'b0, 1'b0);
    stall_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); check_state("midrst_run", 32'h0, 1'b1, 1'b0);
    tick(); check_state("midrst_seq", 32'h4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the combinational PC+4 adder.
- Owns the architectural program counter register and selects next PC from sequential, branch, jump and trap sources.
- Holds PC on pipeline stall and buffers a redirect that arrives during a stall.
- Sits at the head of the fetch stage; drives the instruction memory address and PC+INC to writeback (JAL/JALR link).

Parameters:
XLEN, 32, width of PC and all target buses
INC, 4, sequential increment in bytes
RESET_VECTOR, 32'h0000_0000, PC value on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap (and on misaligned target when the optional check is compiled in)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold PC, pipeline frozen
branch_i  in  1  taken conditional branch this cycle
branch_target_i  in  XLEN  branch destination
jump_i  in  1  JAL/JALR this cycle
jump_target_i  in  XLEN  jump destination, bit0 forced to 0 internally
trap_i  in  1  exception/interrupt redirect
pc_o  out  XLEN  current PC (fetch address)
pc_inc_o  out  XLEN  pc_o + INC, combinational from pc_o
fetch_valid_o  out  1  pc_o is a live fetch this cycle
redirect_pending_o  out  1  a redirect is buffered behind a stall
misalign_o  out  1  one-cycle pulse on misaligned redirect target (0 when feature absent)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate, no clock needed): pc_o=RESET_VECTOR, fetch_valid_o=0, redirect_pending_o=0, misalign_o=0, pending target cleared, state=BOOT.
- States:
  - BOOT: fetch_valid_o=0. Next edge goes to RUN; pc_o unchanged.
  - RUN: fetch_valid_o=1.
  - BUBBLE: fetch_valid_o=0 for exactly one cycle after a redirect is applied; pc_o already holds the target. Next edge goes to RUN.
- Redirect priority per cycle: trap_i > jump_i > branch_i > sequential.
- Redirect target:
  - trap_i: TRAP_VECTOR.
  - jump_i: {jump_target_i[XLEN-1:1],1'b0}.
  - branch_i: branch_target_i.
- RUN, stall_i=0:
  - Redirect or pending present: pc_o <= target (pending wins over sequential; a new trap_i wins over pending). State goes to BUBBLE; pending is cleared.
  - Otherwise: pc_o <= pc_o + INC, modulo 2^XLEN (wrap from max to 0, no flag).
- RUN, stall_i=1:
  - pc_o holds.
  - trap_i: applied immediately regardless of stall. pc_o <= TRAP_VECTOR, state goes to BUBBLE, pending cleared.
  - jump_i/branch_i with no pending: captured into the pending register; redirect_pending_o=1 from the next cycle.
  - jump_i/branch_i with pending already set: the new redirect overwrites the pending target.
- stall_i during BOOT or BUBBLE: state and PC frozen; the redirect capture rules above still apply.
- Latency: redirect to new pc_o is 1 cycle (edge after assertion with stall_i=0). The first valid fetch of the target is one cycle later (BUBBLE).
- pc_inc_o: purely combinational, same wrap rule, no registered delay.
- Reset asserted mid-operation: all state cleared per the reset rule; any pending redirect is lost.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- With the macro:
  - Any non-trap redirect target with bits[1:0]!=2'b00 is not taken.
  - pc_o <= TRAP_VECTOR, misalign_o pulses 1 for one cycle aligned with the new pc_o, state goes to BUBBLE.
  - This applies to both immediate and pending redirects.
- Without the macro: targets are used as given (only jump bit0 cleared); misalign_o is tied to 0.

Test Plan:
- Reset then release, no stall -> pc_o=0x0 in BOOT with fetch_valid_o=0; next cycle fetch_valid_o=1 at 0x0; then 0x4, 0x8.
- At pc_o=0x10, branch_i=1, target=0x200 -> next cycle pc_o=0x200, fetch_valid_o=0 one cycle, then 0x204.
- Same cycle trap_i, jump_i=0x80, branch_i=0x40 -> pc_o=0x100; jump target 0x81 -> pc_o=0x80.
- stall_i=1 for 3 cycles, branch to 0x300 in cycle 1 -> pc_o held, redirect_pending_o=1; after stall drops pc_o=0x300 and pending=0. trap_i during the stall -> pc_o=0x100 immediately, pending cleared.
- pc_o=0xFFFF_FFFC sequential -> next pc_o=0x0; pc_inc_o=0x0 while at 0xFFFF_FFFC.
- PC_MISALIGN_CHK_EN defined, branch target 0x202 -> pc_o=0x100 with misalign_o=1 for one cycle; without the macro -> pc_o=0x202 and misalign_o=0.
